// File: rtl/fetch_stage_pkg.sv
// Shared pipeline types: the fetch-to-decode bundle, the fetch FSM states
// and the PC helpers used by the fetch stage.
package pipeline_types;

    localparam logic [31:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    localparam if_id_t ID_BUBBLE = '{instr: 32'd0, pc: 32'd0, pc4: 32'd0, valid: 1'b0};

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_fifo.sv
// Circular buffer of fetched {instruction, pc} words waiting for decode.
// Clear wins over push/pop; pushes when full and pops when empty are dropped.
module fetch_fifo #(
    parameter  int Depth = 2,
    parameter  int Width = 64,
    localparam int CntW  = $clog2(Depth + 1),
    localparam int PtrW  = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic             iClk,
    input  logic             nRst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_clear,
    input  logic [Width-1:0] i_data,
    output logic [CntW-1:0]  o_count,
    output logic [Width-1:0] o_head
);

    localparam logic [PtrW-1:0] LAST_PTR = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] FULL_CNT = CntW'(Depth);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LAST_PTR) ? {PtrW{1'b0}} : p + PtrW'(1);
    endfunction

    assign w_do_push = i_push & (r_count != FULL_CNT);
    assign w_do_pop  = i_pop & (r_count != {CntW{1'b0}});

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_wr_ptr <= {PtrW{1'b0}};
            r_rd_ptr <= {PtrW{1'b0}};
            r_count  <= {CntW{1'b0}};
        end else if (i_clear) begin
            r_wr_ptr <= {PtrW{1'b0}};
            r_rd_ptr <= {PtrW{1'b0}};
            r_count  <= {CntW{1'b0}};
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone decides what is readable.
    always_ff @(posedge iClk) begin
        if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding memory read at a time, results buffered
// in fetch_fifo and handed to decode through the registered oID bundle.
module fetch_stage
    import pipeline_types::*;
#(
    parameter logic [31:0] ResetVec  = 32'h0000_0000,
    parameter int          FifoDepth = 2
) (
    input  logic        iClk,
    input  logic        nRst,
    input  logic        iStall,
    input  logic        iBrTrue,
    input  logic [31:0] iBrPc,
    output if_id_t      oID,
    output logic        oMemReq,
    output logic [31:0] oMemAddr,
    input  logic        iMemAck,
    input  logic [31:0] iMemData
);

    localparam int          CW       = $clog2(FifoDepth + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FifoDepth);
    localparam logic [31:0] RESET_PC = align_word(ResetVec);

    fetch_state_t r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt, r_mem_addr, w_mem_addr_nxt;
    logic         r_mem_req, w_mem_req_nxt;
    if_id_t       r_id, w_id_nxt;
    logic         w_redirect, w_ack, w_push, w_pop, w_credit;
    logic [CW-1:0] w_count, w_post_count;
    logic [63:0]  w_head;
    logic [31:0]  w_br_pc, w_pc_inc, w_target;

    fetch_fifo #(.Depth(FifoDepth), .Width(64)) u_fifo (
        .iClk    (iClk),
        .nRst    (nRst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_redirect),
        .i_data  ({iMemData, r_pc}),
        .o_count (w_count),
        .o_head  (w_head)
    );

    // Credit is judged on the FIFO occupancy as it will be after this edge.
    always_comb begin
        w_redirect = iBrTrue & ~iStall;
        w_ack      = iMemAck & r_mem_req;
        w_br_pc    = align_word(iBrPc);
        w_pc_inc   = r_pc + PC_STEP;
        w_target   = w_redirect ? w_br_pc : r_pc;
        w_pop      = ~iStall & ~w_redirect & (w_count != {CW{1'b0}});
        w_push     = (r_state == WAIT) & w_ack & ~w_redirect;
        if (w_redirect) begin
            w_post_count = {CW{1'b0}};
        end else if (w_push && !w_pop) begin
            w_post_count = w_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_post_count = w_count - CW'(1);
        end else begin
            w_post_count = w_count;
        end
        w_credit = (w_post_count < DEPTH_C);
    end

    // Request FSM next state; PC always holds the next address to fetch.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_mem_req_nxt  = r_mem_req;
        w_mem_addr_nxt = r_mem_addr;
        case (r_state)
            IDLE: begin
                w_pc_nxt = w_target;
                if (w_credit) begin
                    w_state_nxt    = WAIT;
                    w_mem_req_nxt  = 1'b1;
                    w_mem_addr_nxt = w_target;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (w_ack && w_redirect) begin
                    w_state_nxt    = WAIT;
                    w_pc_nxt       = w_br_pc;
                    w_mem_addr_nxt = w_br_pc;
                end else if (w_ack) begin
                    w_pc_nxt = w_pc_inc;
                    if (w_credit) begin
                        w_state_nxt    = WAIT;
                        w_mem_addr_nxt = w_pc_inc;
                    end else begin
                        w_state_nxt   = IDLE;
                        w_mem_req_nxt = 1'b0;
                    end
                end else if (w_redirect) begin
                    w_state_nxt = DROP;
                    w_pc_nxt    = w_br_pc;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            DROP: begin
                w_pc_nxt = w_target;
                if (w_ack && w_credit) begin
                    w_state_nxt    = WAIT;
                    w_mem_addr_nxt = w_target;
                end else if (w_ack) begin
                    w_state_nxt   = IDLE;
                    w_mem_req_nxt = 1'b0;
                end else begin
                    w_state_nxt = DROP;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_pc_nxt      = RESET_PC;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    // Decode bundle: bubble on redirect, hold on stall, otherwise pop the head.
    always_comb begin
        w_id_nxt = r_id;
        if (w_redirect) begin
            w_id_nxt = ID_BUBBLE;
        end else if (!iStall && (w_count != {CW{1'b0}})) begin
            w_id_nxt = '{instr: w_head[63:32], pc: w_head[31:0],
                         pc4: w_head[31:0] + PC_STEP, valid: 1'b1};
        end else if (!iStall) begin
            w_id_nxt = ID_BUBBLE;
        end else begin
            w_id_nxt = r_id;
        end
    end

    // State and output registers.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_mem_req  <= 1'b0;
            r_mem_addr <= 32'd0;
            r_id       <= ID_BUBBLE;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_mem_req  <= w_mem_req_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_id       <= w_id_nxt;
        end
    end

    assign oID      = r_id;
    assign oMemReq  = r_mem_req;
    assign oMemAddr = r_mem_addr;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized stall/redirect/ack
// traffic, checked against a transaction-level model (queue + pending request).
module tb_fetch_stage;
    import pipeline_types::*;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetched_t;

    logic        iClk = 1'b0;
    logic        nRst;
    logic        iStall, iBrTrue, iMemAck;
    logic [31:0] iBrPc, iMemData;
    if_id_t      oID;
    logic        oMemReq;
    logic [31:0] oMemAddr;

    if_id_t      w_id_w;
    logic        w_req_w;
    logic [31:0] w_addr_w;

    fetch_stage #(.ResetVec(32'h0000_0000), .FifoDepth(DEPTH)) dut (
        .iClk(iClk), .nRst(nRst), .iStall(iStall), .iBrTrue(iBrTrue), .iBrPc(iBrPc),
        .oID(oID), .oMemReq(oMemReq), .oMemAddr(oMemAddr),
        .iMemAck(iMemAck), .iMemData(iMemData)
    );

    // Zero-wait memory that always answers with a NOP, starting at the top of memory.
    fetch_stage #(.ResetVec(32'hFFFF_FFFC), .FifoDepth(DEPTH)) dut_wrap (
        .iClk(iClk), .nRst(nRst), .iStall(1'b0), .iBrTrue(1'b0), .iBrPc(32'd0),
        .oID(w_id_w), .oMemReq(w_req_w), .oMemAddr(w_addr_w),
        .iMemAck(w_req_w), .iMemData(32'h0000_0013)
    );

    always #5 iClk = ~iClk;

    int          n_vec = 0;
    int          n_fail = 0;
    bit          use_nop = 1'b0;
    logic [31:0] m_pc, m_addr;
    bit          m_busy, m_keep;
    if_id_t      m_id, held_id;
    fetched_t    m_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
    endfunction

    task automatic check(input string tag, input logic [96:0] obs, input logic [96:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'd0; m_addr = 32'd0; m_busy = 1'b0; m_keep = 1'b0;
        m_id = ID_BUBBLE;
        m_q.delete();
    endtask

    // One clock edge of the fetch stage seen as transactions.
    task automatic model_edge(input bit stall, input bit br, input logic [31:0] brpc,
                              input bit ack, input logic [31:0] data);
        bit       redirect;
        bit       acked;
        fetched_t f;
        redirect = br && !stall;
        acked    = ack && m_busy;
        if (redirect) begin
            m_q.delete();
            m_id = ID_BUBBLE;
        end else if (!stall) begin
            if (m_q.size() > 0) begin
                f = m_q.pop_front();
                m_id = '{instr: f.instr, pc: f.pc, pc4: f.pc + 32'd4, valid: 1'b1};
            end else begin
                m_id = ID_BUBBLE;
            end
        end
        if (acked) begin
            if (m_keep && !redirect) begin
                f.instr = data;
                f.pc    = m_addr;
                m_q.push_back(f);
                m_pc = m_addr + 32'd4;
            end
            m_busy = 1'b0;
        end
        if (redirect) m_pc = {brpc[31:2], 2'b00};
        if (m_busy) begin
            if (redirect) m_keep = 1'b0;
        end else if (m_q.size() < DEPTH) begin
            m_busy = 1'b1;
            m_keep = 1'b1;
            m_addr = m_pc;
        end
    endtask

    task automatic step(input bit stall, input bit br, input logic [31:0] brpc, input bit ack);
        logic [31:0] data;
        if (use_nop) data = 32'h0000_0013;
        else if (ack) data = mem_word(oMemAddr);
        else data = $urandom();
        iStall = stall; iBrTrue = br; iBrPc = brpc; iMemAck = ack; iMemData = data;
        model_edge(stall, br, brpc, ack, data);
        @(posedge iClk); #1;
        check("oID", oID, m_id);
        check("oMemReq", 97'(oMemReq), 97'(m_busy));
        if (m_busy) check("oMemAddr", 97'(oMemAddr), 97'(m_addr));
    endtask

    task automatic check_reset_outputs();
        check("rst_oID", oID, 97'd0);
        check("rst_oMemReq", 97'(oMemReq), 97'd0);
        check("rst_oMemAddr", 97'(oMemAddr), 97'd0);
    endtask

    // Asynchronous reset pulse issued between edges.
    task automatic do_reset();
        iStall = 1'b0; iBrTrue = 1'b0; iMemAck = 1'b0;
        nRst = 1'b0;
        #1;
        model_reset();
        check_reset_outputs();
        @(posedge iClk); #1;
        nRst = 1'b1;
    endtask

    initial begin
        nRst = 1'b0; iStall = 1'b0; iBrTrue = 1'b0; iBrPc = 32'd0;
        iMemAck = 1'b0; iMemData = 32'd0;
        model_reset();
        @(posedge iClk); #1;
        @(posedge iClk); #1;
        check_reset_outputs();
        nRst = 1'b1;

        // Zero-wait streaming of NOPs from address 0; top-of-memory wrap on dut_wrap.
        use_nop = 1'b1;
        step(1'b0, 1'b0, 32'd0, 1'b0);
        check("s033_addr0", 97'(oMemAddr), 97'h0);
        check("wrap_addr0", 97'(w_addr_w), 97'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("s033_addr4", 97'(oMemAddr), 97'h4);
        check("wrap_addr1", 97'(w_addr_w), 97'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b1);
            check("s033_pc", 97'(oID.pc), 97'(4 * i));
            check("s033_valid", 97'(oID.valid), 97'h1);
            check("s033_instr", 97'(oID.instr), 97'h13);
            if (i == 0) begin
                check("s033_addr8", 97'(oMemAddr), 97'h8);
                check("wrap_id", w_id_w, {32'h13, 32'hFFFF_FFFC, 32'h0, 1'b1});
            end
        end

        // Stall for four cycles while acks keep arriving.
        held_id = m_id;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'd0, 1'b1);
            check("s034_hold", oID, held_id);
        end
        check("s034_noreq", 97'(oMemReq), 97'h0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'd0, 1'b1);
        use_nop = 1'b0;

        // Redirect to 0x100 while the request to 0x8 is still pending.
        do_reset();
        step(1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("s035_addr8", 97'(oMemAddr), 97'h8);
        step(1'b0, 1'b1, 32'h0000_0100, 1'b0);
        check("s035_bubble", 97'(oID.valid), 97'h0);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("s035_addr100", 97'(oMemAddr), 97'h100);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, 1'b1);

        // Redirect to 0x202 in the same cycle as the ack for 0x10.
        do_reset();
        step(1'b0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, 1'b1);
        check("s036_addr10", 97'(oMemAddr), 97'h10);
        step(1'b0, 1'b1, 32'h0000_0202, 1'b1);
        check("s036_addr200", 97'(oMemAddr), 97'h200);
        check("s036_bubble", 97'(oID.valid), 97'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, 1'b1);

        // Reset in the middle of a request, followed by a stray ack.
        step(1'b0, 1'b0, 32'd0, 1'b0);
        check("s038_busy", 97'(oMemReq), 97'h1);
        do_reset();
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("s038_addr", 97'(oMemAddr), 97'h0);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        check("s038_nopush", 97'(oID.valid), 97'h0);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        check("s038_nopush2", 97'(oID.valid), 97'h0);

        // Randomized traffic: stalls, redirects (some while stalled), sparse acks.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step(($urandom() % 4) == 0, ($urandom() % 10) == 0, $urandom(),
                 ($urandom() % 2) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter ResetVec, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter FifoDepth, default 2, meaning the number of fetched-instruction buffer entries.
REQ-003 SHALL have port iClk, input, 1, clock; all state SHALL update on the rising edge.
REQ-004 SHALL have port nRst, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port iStall, input, 1, meaning decode holds and oID must not change.
REQ-006 SHALL have port iBrTrue, input, 1, meaning a redirect request from decode.
REQ-007 SHALL have port iBrPc, input, 32, meaning the redirect target address.
REQ-008 SHALL have port oID, output, if_id_t, meaning the registered fetch-to-decode bundle {instruction, pc, pc4, valid}.
REQ-009 SHALL have port oMemReq, output, 1, meaning an instruction-memory read request (registered).
REQ-010 SHALL have port oMemAddr, output, 32, meaning the request word address (registered, bits [1:0] always 0).
REQ-011 SHALL have port iMemAck, input, 1, meaning a one-cycle pulse that completes the outstanding request.
REQ-012 SHALL have port iMemData, input, 32, meaning the instruction word, valid only while iMemAck=1.

Function
REQ-013 SHALL keep at most one memory request outstanding; oMemReq and oMemAddr SHALL hold stable until the cycle iMemAck=1.
REQ-014 SHALL accept iMemAck in any cycle in which oMemReq=1, including the first such cycle; iMemAck while oMemReq=0 SHALL be ignored.
REQ-015 SHALL use the FSM states IDLE (oMemReq=0), WAIT (oMemReq=1, result kept) and DROP (oMemReq=1, result discarded).
REQ-016 From IDLE, the block SHALL move to WAIT with oMemAddr=PC when a buffer credit exists, i.e. the post-edge FIFO count plus outstanding requests is less than FifoDepth.
REQ-017 In WAIT with ack and no redirect, the block SHALL push {iMemData, PC} into the FIFO and set PC=PC+4, then go to WAIT with the new address if a credit remains, else go to IDLE.
REQ-018 In WAIT with no ack and a redirect, the block SHALL go to DROP and set PC=iBrPc.
REQ-019 In WAIT with ack and a redirect in the same cycle, the block SHALL discard the data and go to WAIT with oMemAddr=iBrPc.
REQ-020 In DROP with ack, the block SHALL discard iMemData and go to WAIT with oMemAddr=PC; a further redirect in DROP SHALL only update PC.
REQ-021 A redirect SHALL be actioned only when iBrTrue=1 and iStall=0; iBrTrue while stalled SHALL be ignored.
REQ-022 On a redirect, the block SHALL clear the FIFO, load oID with a bubble (all fields 0), and load PC with {iBrPc[31:2],2'b00}.
REQ-023 When iStall=0 and there is no redirect, oID SHALL load the FIFO head with valid=1 and pc4=pc+4, popping the entry, or a bubble if the FIFO is empty.
REQ-024 When iStall=1, oID and the FIFO head SHALL hold; pushes from ack SHALL still occur, and credit accounting SHALL prevent overflow.
REQ-025 A push and a pop in the same edge SHALL leave the count unchanged; a push into an empty FIFO SHALL become visible on oID no earlier than the following edge.
REQ-026 Latency from an ack edge into an empty FIFO to oID.valid=1 SHALL be one edge (when not stalled); back-to-back single-cycle acks SHALL sustain one instruction per cycle.
REQ-027 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 SHALL wrap to 0.

Reset
REQ-028 While nRst=0, the outputs SHALL be oID='0, oMemReq=0 and oMemAddr=0, with state IDLE, FIFO count 0 and PC=ResetVec.
REQ-029 On the first edge after nRst release, the block SHALL assert oMemReq with oMemAddr=ResetVec.
REQ-030 Reset asserted mid-request SHALL abandon the request, and a late iMemAck after release SHALL be ignored because the state is IDLE.

Structure
REQ-031 if_id_t, including the valid field, SHALL reside in pipeline_types; the FSM state enum SHALL reside in pipeline_types as fetch_state_t.
REQ-032 The FIFO SHALL be the sub-module fetch_fifo, parameterised by depth and width and providing push, pop, clear, count and head.

Verification
REQ-033 Reset release with zero-wait ack and ResetVec=0, iMemData=0x00000013 SHALL produce oMemAddr 0,4,8 on consecutive cycles and oID.pc 0,4,8 with valid=1 from cycle 2.
REQ-034 iStall held for 4 cycles during streaming SHALL hold oID constant, fill the FIFO to 2, drop oMemReq to 0, and on release resume with no lost or duplicated pc.
REQ-035 Redirect to iBrPc=0x100 while a request to 0x8 awaits ack 3 cycles later SHALL enter DROP, discard the 0x8 data, next request 0x100, and set oID.valid=0 after the redirect edge.
REQ-036 Redirect coinciding with ack for 0x10 SHALL discard that data, and the next oMemAddr SHALL equal 0x200 (iBrPc=0x202, low bits cleared).
REQ-037 ResetVec=0xFFFFFFFC SHALL make the second request wrap to address 0x0.
REQ-038 nRst pulsed low while in WAIT, followed by a stray iMemAck, SHALL produce no FIFO push and a fresh request to ResetVec.
